// File: rtl/seq_mod_pkg.sv
// seq_mod_pkg: shared state encoding and width helpers for the streaming
// divisibility checker and its remainder step.
package seq_mod_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits needed to hold a remainder in 0..divisor-1.
  function automatic int rem_width(input int divisor);
    return $clog2(divisor);
  endfunction

  // Bits needed for rem*radix + digit before reduction, with room for any
  // 4-bit digit value, not just legal ones.
  function automatic int int_width(input int radix, input int divisor);
    return $clog2((divisor - 1) * radix + 16);
  endfunction

  // Bits needed to count 0..max_digits inclusive.
  function automatic int count_width(input int max_digits);
    return $clog2(max_digits + 1);
  endfunction

endpackage

// File: rtl/seq_mod_checker_if.sv
// seq_mod_checker_if: digit stream handshake plus result/status signals.
// The master side is the digit source, the slave side is the checker.
interface seq_mod_checker_if
  import seq_mod_pkg::*;
#(
  parameter int DIVISOR    = 3,
  parameter int MAX_DIGITS = 16
);

  localparam int REM_W = rem_width(DIVISOR);
  localparam int CNT_W = count_width(MAX_DIGITS);

  logic             start;
  logic             digit_valid;
  logic [3:0]       digit;
  logic             last;
  logic             digit_ready;
  logic [REM_W-1:0] rem;
  logic             divisible;
  logic [CNT_W-1:0] digit_count;
  logic             done;
  logic             overflow;
  logic             digit_err;

  modport master (
    output start, digit_valid, digit, last,
    input  digit_ready, rem, divisible, digit_count, done, overflow, digit_err
  );

  modport slave (
    input  start, digit_valid, digit, last,
    output digit_ready, rem, divisible, digit_count, done, overflow, digit_err
  );

endinterface

// File: rtl/mod_step.sv
// mod_step: one remainder update, (rem*RADIX + digit) mod DIVISOR, done at
// full intermediate width so nothing is lost before the reduction.
module mod_step
  import seq_mod_pkg::*;
#(
  parameter int RADIX   = 10,
  parameter int DIVISOR = 3
) (
  input  logic [rem_width(DIVISOR)-1:0] rem,
  input  logic [3:0]                    digit,
  output logic [rem_width(DIVISOR)-1:0] next_rem
);

  localparam int REM_W = rem_width(DIVISOR);
  localparam int INT_W = int_width(RADIX, DIVISOR);
  localparam logic [INT_W-1:0] RADIX_W   = INT_W'(RADIX);
  localparam logic [INT_W-1:0] DIVISOR_W = INT_W'(DIVISOR);

  if (RADIX < 2 || RADIX > 16 || DIVISOR < 2 || DIVISOR > 255) begin : g_bad_params
    $error("mod_step: RADIX must be 2..16 and DIVISOR 2..255");
  end

  logic [INT_W-1:0] wide;

  // Shift the running remainder up one digit position, add the digit, reduce.
  always_comb begin
    wide     = INT_W'(rem) * RADIX_W + INT_W'(digit);
    next_rem = REM_W'(wide % DIVISOR_W);
  end

endmodule

// File: rtl/seq_mod_checker.sv
// seq_mod_checker: MSB-first radix-RADIX digit stream, running remainder
// modulo DIVISOR, framed by start/last with done pulse and sticky flags.
// Optional macro SEQMOD_DIGIT_CHECK_EN: reject digits >= RADIX and flag
// them on digit_err; without it any 4-bit value is folded in as given.
module seq_mod_checker
  import seq_mod_pkg::*;
#(
  parameter int RADIX      = 10,
  parameter int DIVISOR    = 3,
  parameter int MAX_DIGITS = 16
) (
  input logic              clk,
  input logic              reset,
  seq_mod_checker_if.slave bus
);

  localparam int REM_W = rem_width(DIVISOR);
  localparam int CNT_W = count_width(MAX_DIGITS);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DIGITS);

  if (MAX_DIGITS < 1 || MAX_DIGITS > 65535) begin : g_bad_max
    $error("seq_mod_checker: MAX_DIGITS must be 1..65535");
  end

  state_t           state;
  logic [REM_W-1:0] rem_q;
  logic [REM_W-1:0] next_rem;
  logic [CNT_W-1:0] count_q;
  logic             divisible_q;
  logic             ready_q;
  logic             done_q;
  logic             overflow_q;
  logic             digit_legal;

  mod_step #(
    .RADIX  (RADIX),
    .DIVISOR(DIVISOR)
  ) u_step (
    .rem     (rem_q),
    .digit   (bus.digit),
    .next_rem(next_rem)
  );

`ifdef SEQMOD_DIGIT_CHECK_EN
  logic err_q;
  assign digit_legal   = (5'(bus.digit) < 5'(RADIX));
  assign bus.digit_err = err_q;
`else
  assign digit_legal   = 1'b1;
  assign bus.digit_err = 1'b0;
`endif

  // Framing FSM; every output is a register so digit_ready never depends
  // combinationally on digit_valid, and start always wins over a digit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rem_q       <= '0;
      count_q     <= '0;
      divisible_q <= 1'b1;
      ready_q     <= 1'b0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
`ifdef SEQMOD_DIGIT_CHECK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (bus.start) begin
        state       <= RUN;
        rem_q       <= '0;
        count_q     <= '0;
        divisible_q <= 1'b1;
        ready_q     <= 1'b1;
        overflow_q  <= 1'b0;
`ifdef SEQMOD_DIGIT_CHECK_EN
        err_q       <= 1'b0;
`endif
      end else begin
        case (state)
          RUN: begin
            if (bus.digit_valid) begin
              if (digit_legal) begin
                rem_q       <= next_rem;
                divisible_q <= (next_rem == '0);
                if (count_q == CNT_MAX) begin
                  overflow_q <= 1'b1;
                end else begin
                  count_q <= count_q + CNT_W'(1);
                end
              end
`ifdef SEQMOD_DIGIT_CHECK_EN
              if (!digit_legal) begin
                err_q <= 1'b1;
              end
`endif
              if (bus.last) begin
                state   <= DONE;
                ready_q <= 1'b0;
                done_q  <= 1'b1;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign bus.digit_ready = ready_q;
  assign bus.rem         = rem_q;
  assign bus.divisible   = divisible_q;
  assign bus.digit_count = count_q;
  assign bus.done        = done_q;
  assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_seq_mod_checker.sv
// tb_seq_mod_checker: directed checks of seq_mod_checker on three
// configurations (10/3/16, 10/7/16, 16/5/2) fed the same digit stream.
module tb_seq_mod_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_s = 1'b0;
  logic       valid_s = 1'b0;
  logic       last_s = 1'b0;
  logic [3:0] digit_s = 4'd0;
  int         checks = 0;
  int         failures = 0;

  seq_mod_checker_if #(.DIVISOR(3), .MAX_DIGITS(16)) bus_a ();
  seq_mod_checker_if #(.DIVISOR(7), .MAX_DIGITS(16)) bus_b ();
  seq_mod_checker_if #(.DIVISOR(5), .MAX_DIGITS(2))  bus_c ();

  assign bus_a.start = start_s;
  assign bus_a.digit_valid = valid_s;
  assign bus_a.digit = digit_s;
  assign bus_a.last = last_s;
  assign bus_b.start = start_s;
  assign bus_b.digit_valid = valid_s;
  assign bus_b.digit = digit_s;
  assign bus_b.last = last_s;
  assign bus_c.start = start_s;
  assign bus_c.digit_valid = valid_s;
  assign bus_c.digit = digit_s;
  assign bus_c.last = last_s;

  seq_mod_checker #(.RADIX(10), .DIVISOR(3), .MAX_DIGITS(16)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a.slave));
  seq_mod_checker #(.RADIX(10), .DIVISOR(7), .MAX_DIGITS(16)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b.slave));
  seq_mod_checker #(.RADIX(16), .DIVISOR(5), .MAX_DIGITS(2)) dut_c (
    .clk(clk), .reset(reset), .bus(bus_c.slave));

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Drive one cycle of inputs, let the edge take them, sample 1 unit later.
  task automatic apply_stimulus(input logic s, input logic v, input logic [3:0] d, input logic l);
    start_s = s;
    valid_s = v;
    digit_s = d;
    last_s  = l;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    apply_stimulus(1'b1, 1'b1, 4'd3, 1'b1);
    apply_stimulus(1'b0, 1'b0, 4'd0, 1'b0);
    checks++; if (bus_a.rem !== 2'd0) begin failures++; $display("[TB] FAIL reset_rem got=%0d exp=0", bus_a.rem); end
    checks++; if (bus_a.divisible !== 1'b1) begin failures++; $display("[TB] FAIL reset_divisible got=%0d exp=1", bus_a.divisible); end
    checks++; if (bus_a.digit_count !== 5'd0) begin failures++; $display("[TB] FAIL reset_count got=%0d exp=0", bus_a.digit_count); end
    checks++; if (bus_a.done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got=%0d exp=0", bus_a.done); end
    checks++; if (bus_a.overflow !== 1'b0) begin failures++; $display("[TB] FAIL reset_overflow got=%0d exp=0", bus_a.overflow); end
    checks++; if (bus_a.digit_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_digit_err got=%0d exp=0", bus_a.digit_err); end
    checks++; if (bus_a.digit_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_ready got=%0d exp=0", bus_a.digit_ready); end
    reset = 1'b0;
    apply_stimulus(1'b0, 1'b1, 4'd4, 1'b0);
    checks++; if (bus_a.digit_count !== 5'd0) begin failures++; $display("[TB] FAIL idle_ignores_digit got=%0d exp=0", bus_a.digit_count); end
  endtask

  task automatic test_divisible_123;
    apply_stimulus(1'b1, 1'b0, 4'd0, 1'b0);
    checks++; if (bus_a.digit_ready !== 1'b1) begin failures++; $display("[TB] FAIL start_ready got=%0d exp=1", bus_a.digit_ready); end
    apply_stimulus(1'b0, 1'b1, 4'd1, 1'b0);
    checks++; if (bus_a.rem !== 2'd1) begin failures++; $display("[TB] FAIL d1_rem got=%0d exp=1", bus_a.rem); end
    checks++; if (bus_a.digit_count !== 5'd1) begin failures++; $display("[TB] FAIL d1_count got=%0d exp=1", bus_a.digit_count); end
    apply_stimulus(1'b0, 1'b1, 4'd2, 1'b0);
    checks++; if (bus_a.rem !== 2'd0) begin failures++; $display("[TB] FAIL d12_rem got=%0d exp=0", bus_a.rem); end
    apply_stimulus(1'b0, 1'b1, 4'd3, 1'b1);
    checks++; if (bus_a.rem !== 2'd0) begin failures++; $display("[TB] FAIL d123_rem got=%0d exp=0", bus_a.rem); end
    checks++; if (bus_a.divisible !== 1'b1) begin failures++; $display("[TB] FAIL d123_divisible got=%0d exp=1", bus_a.divisible); end
    checks++; if (bus_a.digit_count !== 5'd3) begin failures++; $display("[TB] FAIL d123_count got=%0d exp=3", bus_a.digit_count); end
    checks++; if (bus_a.done !== 1'b1) begin failures++; $display("[TB] FAIL d123_done got=%0d exp=1", bus_a.done); end
    checks++; if (bus_a.digit_ready !== 1'b0) begin failures++; $display("[TB] FAIL d123_ready got=%0d exp=0", bus_a.digit_ready); end
    apply_stimulus(1'b0, 1'b1, 4'd5, 1'b1);
    checks++; if (bus_a.done !== 1'b0) begin failures++; $display("[TB] FAIL done_one_cycle got=%0d exp=0", bus_a.done); end
    checks++; if (bus_a.digit_count !== 5'd3) begin failures++; $display("[TB] FAIL done_hold_count got=%0d exp=3", bus_a.digit_count); end
    checks++; if (bus_a.rem !== 2'd0) begin failures++; $display("[TB] FAIL done_hold_rem got=%0d exp=0", bus_a.rem); end
    apply_stimulus(1'b0, 1'b0, 4'd0, 1'b0);
    checks++; if (bus_a.done !== 1'b0) begin failures++; $display("[TB] FAIL done_stays_low got=%0d exp=0", bus_a.done); end
  endtask

  task automatic test_fresh_start;
    apply_stimulus(1'b1, 1'b0, 4'd0, 1'b0);
    apply_stimulus(1'b0, 1'b1, 4'd1, 1'b0);
    apply_stimulus(1'b0, 1'b1, 4'd0, 1'b0);
    checks++; if (bus_a.rem !== 2'd1) begin failures++; $display("[TB] FAIL d10_rem got=%0d exp=1", bus_a.rem); end
    checks++; if (bus_a.divisible !== 1'b0) begin failures++; $display("[TB] FAIL d10_divisible got=%0d exp=0", bus_a.divisible); end
    checks++; if (bus_a.digit_count !== 5'd2) begin failures++; $display("[TB] FAIL d10_count got=%0d exp=2", bus_a.digit_count); end
    apply_stimulus(1'b1, 1'b0, 4'd0, 1'b0);
    checks++; if (bus_a.rem !== 2'd0) begin failures++; $display("[TB] FAIL restart_rem got=%0d exp=0", bus_a.rem); end
    checks++; if (bus_a.digit_count !== 5'd0) begin failures++; $display("[TB] FAIL restart_count got=%0d exp=0", bus_a.digit_count); end
    checks++; if (bus_a.divisible !== 1'b1) begin failures++; $display("[TB] FAIL restart_divisible got=%0d exp=1", bus_a.divisible); end
  endtask

  task automatic test_radix10_div7;
    apply_stimulus(1'b1, 1'b0, 4'd0, 1'b0);
    apply_stimulus(1'b0, 1'b1, 4'd9, 1'b0);
    checks++; if (bus_b.rem !== 3'd2) begin failures++; $display("[TB] FAIL div7_9_rem got=%0d exp=2", bus_b.rem); end
    apply_stimulus(1'b0, 1'b1, 4'd8, 1'b1);
    checks++; if (bus_b.rem !== 3'd0) begin failures++; $display("[TB] FAIL div7_98_rem got=%0d exp=0", bus_b.rem); end
    checks++; if (bus_b.divisible !== 1'b1) begin failures++; $display("[TB] FAIL div7_98_divisible got=%0d exp=1", bus_b.divisible); end
    apply_stimulus(1'b1, 1'b0, 4'd0, 1'b0);
    apply_stimulus(1'b0, 1'b1, 4'd9, 1'b0);
    apply_stimulus(1'b0, 1'b1, 4'd9, 1'b1);
    checks++; if (bus_b.rem !== 3'd1) begin failures++; $display("[TB] FAIL div7_99_rem got=%0d exp=1", bus_b.rem); end
    checks++; if (bus_b.divisible !== 1'b0) begin failures++; $display("[TB] FAIL div7_99_divisible got=%0d exp=0", bus_b.divisible); end
  endtask

  task automatic test_hex_overflow;
    apply_stimulus(1'b1, 1'b0, 4'd0, 1'b0);
    apply_stimulus(1'b0, 1'b1, 4'hF, 1'b0);
    apply_stimulus(1'b0, 1'b1, 4'hF, 1'b0);
    checks++; if (bus_c.rem !== 3'd0) begin failures++; $display("[TB] FAIL hex_ff_rem got=%0d exp=0", bus_c.rem); end
    checks++; if (bus_c.digit_count !== 2'd2) begin failures++; $display("[TB] FAIL hex_ff_count got=%0d exp=2", bus_c.digit_count); end
    checks++; if (bus_c.overflow !== 1'b0) begin failures++; $display("[TB] FAIL hex_ff_overflow got=%0d exp=0", bus_c.overflow); end
    apply_stimulus(1'b0, 1'b1, 4'd1, 1'b1);
    checks++; if (bus_c.overflow !== 1'b1) begin failures++; $display("[TB] FAIL hex_ovf_flag got=%0d exp=1", bus_c.overflow); end
    checks++; if (bus_c.digit_count !== 2'd2) begin failures++; $display("[TB] FAIL hex_ovf_count got=%0d exp=2", bus_c.digit_count); end
    checks++; if (bus_c.rem !== 3'd1) begin failures++; $display("[TB] FAIL hex_ovf_rem got=%0d exp=1", bus_c.rem); end
    checks++; if (bus_c.done !== 1'b1) begin failures++; $display("[TB] FAIL hex_ovf_done got=%0d exp=1", bus_c.done); end
  endtask

  task automatic test_digit_check;
    logic [4:0] exp_count;
    logic       exp_err;
`ifdef SEQMOD_DIGIT_CHECK_EN
    exp_count = 5'd2;
    exp_err   = 1'b1;
`else
    exp_count = 5'd3;
    exp_err   = 1'b0;
`endif
    apply_stimulus(1'b1, 1'b0, 4'd0, 1'b0);
    apply_stimulus(1'b0, 1'b1, 4'd4, 1'b0);
    apply_stimulus(1'b0, 1'b1, 4'd12, 1'b0);
    apply_stimulus(1'b0, 1'b1, 4'd2, 1'b1);
    checks++; if (bus_a.rem !== 2'd0) begin failures++; $display("[TB] FAIL chk_rem got=%0d exp=0", bus_a.rem); end
    checks++; if (bus_a.digit_count !== exp_count) begin failures++; $display("[TB] FAIL chk_count got=%0d exp=%0d", bus_a.digit_count, exp_count); end
    checks++; if (bus_a.digit_err !== exp_err) begin failures++; $display("[TB] FAIL chk_digit_err got=%0d exp=%0d", bus_a.digit_err, exp_err); end
    checks++; if (bus_a.done !== 1'b1) begin failures++; $display("[TB] FAIL chk_done got=%0d exp=1", bus_a.done); end
  endtask

  task automatic test_mid_start;
    apply_stimulus(1'b1, 1'b0, 4'd0, 1'b0);
    apply_stimulus(1'b0, 1'b1, 4'd5, 1'b0);
    checks++; if (bus_a.rem !== 2'd2) begin failures++; $display("[TB] FAIL mid_d5_rem got=%0d exp=2", bus_a.rem); end
    apply_stimulus(1'b1, 1'b1, 4'd1, 1'b0);
    checks++; if (bus_a.rem !== 2'd0) begin failures++; $display("[TB] FAIL mid_start_rem got=%0d exp=0", bus_a.rem); end
    checks++; if (bus_a.digit_count !== 5'd0) begin failures++; $display("[TB] FAIL mid_start_count got=%0d exp=0", bus_a.digit_count); end
    checks++; if (bus_a.digit_ready !== 1'b1) begin failures++; $display("[TB] FAIL mid_start_ready got=%0d exp=1", bus_a.digit_ready); end
    apply_stimulus(1'b0, 1'b1, 4'd6, 1'b1);
    checks++; if (bus_a.rem !== 2'd0) begin failures++; $display("[TB] FAIL mid_d6_rem got=%0d exp=0", bus_a.rem); end
    checks++; if (bus_a.digit_count !== 5'd1) begin failures++; $display("[TB] FAIL mid_d6_count got=%0d exp=1", bus_a.digit_count); end
    checks++; if (bus_a.done !== 1'b1) begin failures++; $display("[TB] FAIL mid_d6_done got=%0d exp=1", bus_a.done); end
  endtask

  task automatic test_mid_reset;
    apply_stimulus(1'b1, 1'b0, 4'd0, 1'b0);
    apply_stimulus(1'b0, 1'b1, 4'd7, 1'b0);
    checks++; if (bus_a.rem !== 2'd1) begin failures++; $display("[TB] FAIL rst_d7_rem got=%0d exp=1", bus_a.rem); end
    reset = 1'b1;
    apply_stimulus(1'b1, 1'b1, 4'd2, 1'b1);
    checks++; if (bus_a.rem !== 2'd0) begin failures++; $display("[TB] FAIL rst_rem got=%0d exp=0", bus_a.rem); end
    checks++; if (bus_a.divisible !== 1'b1) begin failures++; $display("[TB] FAIL rst_divisible got=%0d exp=1", bus_a.divisible); end
    checks++; if (bus_a.digit_count !== 5'd0) begin failures++; $display("[TB] FAIL rst_count got=%0d exp=0", bus_a.digit_count); end
    checks++; if (bus_a.done !== 1'b0) begin failures++; $display("[TB] FAIL rst_done got=%0d exp=0", bus_a.done); end
    checks++; if (bus_a.digit_ready !== 1'b0) begin failures++; $display("[TB] FAIL rst_ready got=%0d exp=0", bus_a.digit_ready); end
    reset = 1'b0;
    apply_stimulus(1'b0, 1'b0, 4'd0, 1'b0);
    checks++; if (bus_a.done !== 1'b0) begin failures++; $display("[TB] FAIL rst_after_done got=%0d exp=0", bus_a.done); end
    checks++; if (bus_a.digit_ready !== 1'b0) begin failures++; $display("[TB] FAIL rst_after_ready got=%0d exp=0", bus_a.digit_ready); end
  endtask

  // Scenario sequence followed by the single summary line.
  initial begin
    $display("[TB] seq_mod_checker directed tests");
    test_reset();
    test_divisible_123();
    test_fresh_start();
    test_radix10_div7();
    test_hex_overflow();
    test_digit_check();
    test_mid_start();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_mod_checker.md
# seq_mod_checker

Streaming divisibility checker, parametrised successor to the BCD divide-by-3 checker in the lab-3 sequential set. It accepts an MSB-first stream of radix-RADIX digits over a valid/ready handshake and keeps a running remainder modulo DIVISOR. It frames each number with start/last, reports remainder, divisibility, digit count and a done pulse, and flags illegal digits and length overflow. It sits between a digit source (keypad decoder, UART digit parser) and display/LED logic.

## Interface
- RADIX, 10, digit base (2..16)
- DIVISOR, 3, modulus (2..255)
- MAX_DIGITS, 16, digit-count limit per number (1..65535)
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  begin new number: clears remainder, count, flags
- digit_valid  in  1  digit/last valid this cycle
- digit  in  4  digit value, MSB-first
- last  in  1  qualifies final digit of number
- digit_ready  out  1  block accepts digit this cycle
- rem  out  $clog2(DIVISOR)  running remainder
- divisible  out  1  rem == 0
- digit_count  out  $clog2(MAX_DIGITS+1)  digits accepted this number
- done  out  1  one-cycle pulse, number complete
- overflow  out  1  sticky, more than MAX_DIGITS digits offered
- digit_err  out  1  sticky, digit >= RADIX (see Configuration)

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE; rem=0, divisible=1, digit_count=0, done=0, overflow=0, digit_err=0, digit_ready=0.
- IDLE/DONE: start → RUN; rem, count and sticky flags cleared. Digits ignored (digit_ready=0).
- RUN: digit_ready=1. Accept when digit_valid && digit_ready: rem ← (rem*RADIX + digit) mod DIVISOR; digit_count +1.
- Intermediate rem*RADIX+digit is computed at width $clog2((DIVISOR-1)*RADIX+16); no truncation before the reduction.
- last on an accepted digit → DONE. done pulses in the cycle after acceptance.
- DONE holds rem, divisible, count, flags until start or reset.
- Overflow: accepting a digit with digit_count == MAX_DIGITS sets overflow. Count saturates. The remainder still updates.
- start in RUN restarts: the state is cleared, any digit in that same cycle is dropped, and the block stays in RUN.
- reset overrides start and digit in the same cycle. Reset mid-number discards it and no done is produced.

## Timing
- rem, divisible and digit_count update on the clock edge that accepts a digit, and are visible the next cycle.
- Throughput is one digit per cycle. digit_ready depends only on state, not combinationally on digit_valid.
- done is registered. It is high exactly one cycle, the cycle after the last-digit handshake.
- start to first acceptable digit: 1 cycle (RUN is entered on the edge that samples start).

## Configuration
- SEQMOD_DIGIT_CHECK_EN defined: an accepted digit >= RADIX sets digit_err. The digit leaves rem and count unchanged, but its last flag is still honoured.
- Undefined: there is no check and digit_err is tied 0. Any 4-bit value is folded in arithmetically as given, matching legacy BCD-checker behaviour.

## Structure
- Package seq_mod_pkg:
  - state enum (IDLE/RUN/DONE)
  - width helper functions: rem width, intermediate width, count width
- Sub-module mod_step: combinational (rem, digit) → (rem*RADIX+digit) mod DIVISOR, parametrised by RADIX/DIVISOR, with an elaboration-time check on parameter ranges.
- Top level: FSM, registers, handshake, flags.

## Test plan
- Defaults. start; digits 1,2,3 (last on 3) → rem=0, divisible=1, digit_count=3, done pulses once, then holds.
- Defaults. Digits 1,0 → rem=1 after the second digit, divisible=0. A fresh start clears to rem=0, count=0.
- RADIX=10, DIVISOR=7. Digits 9,8 → rem=0 (98=14·7). Digits 9,9 → rem=1.
- RADIX=16, DIVISOR=5. Digits F,F → rem=0 (255). MAX_DIGITS=2 with a third digit 1 → overflow=1, count=2, rem=1.
- Macro on, defaults. Digits 4, 12, 2 (last) → digit_err=1, rem=0 (42), count=2. Macro off: same stream → rem=(4·100+12·10+2) mod 3=0, count=3, digit_err=0.
- Mid-stream start after digit 5, then digits 6 (last) → rem=0, count=1. Mid-stream reset → IDLE with all outputs at reset values and no done pulse.
